// File: rtl/obi_tb_pkg.sv
// rtl/obi_tb_pkg.sv - shared types and helpers for the OBI memory responder
package obi_tb_pkg;

    localparam int OBI_ADDR_W = 32;

    // One queued response: read data (0 for writes/errors) and error flag
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    // Replace the bytes of old selected by be with the matching bytes of wdata
    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// rtl/obi_rsp_fifo.sv - in-order response FIFO with per-entry latency counters
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i/push_data_i  enqueue a response (ignored when full)
//   pop_i             dequeue the head (only honoured when head_ready_o)
//   head_ready_o      head is valid and its latency counter has reached 0
//   head_data_o       head entry contents
//   full_o, count_o   occupancy status
module obi_rsp_fifo
    import obi_tb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  obi_rsp_t         push_data_i,
    input  logic             pop_i,
    output logic             head_ready_o,
    output obi_rsp_t         head_data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    obi_rsp_t         data_q [DEPTH];
    logic [LAT_W-1:0] lat_q  [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign count_o      = count_q;
    assign head_ready_o = (count_q != '0) && (lat_q[rptr_q] == '0);
    assign head_data_o  = data_q[rptr_q];
    assign do_push      = push_i & ~full_o;
    assign do_pop       = pop_i & head_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lat_q[i] <= '0;
            end
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
            // Stale slots also count down; they are reloaded on push, so it is harmless
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (wptr_q == PTR_W'(i))) begin
                    lat_q[i] <= LAT_W'(LATENCY - 1);
                end else if (lat_q[i] != '0) begin
                    lat_q[i] <= lat_q[i] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) data_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI memory responder with in-order fixed-latency responses
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   stall_i        forces gnt_o low (grant-stall injection)
//   req_i/gnt_o    request handshake; accepted when both high at a rising edge
//   addr_i, we_i, be_i, wdata_i  request attributes (addr_i[1:0] ignored)
//   rvalid_o, rdata_o, err_o      one-cycle registered response
//   outstanding_o  accepted-but-unanswered transaction count
module obi_mem_responder
    import obi_tb_pkg::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RVALID_LATENCY  = 1,
    localparam int OCC_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [OBI_ADDR_W-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic [OCC_W-1:0]      outstanding_o
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]      mem [MEM_WORDS];
    logic [29:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             in_range;
    logic             accept;
    logic             full;
    logic             head_ready;
    obi_rsp_t         head_rsp;
    obi_rsp_t         push_rsp;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr_i[1:0];
    assign word_idx = addr_i[OBI_ADDR_W-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = ({2'b00, word_idx} < 32'(MEM_WORDS));

    // No full-bypass: a pop in the same cycle does not reopen the grant
    assign gnt_o  = req_i & ~stall_i & ~full & ~rst_i;
    assign accept = req_i & gnt_o;

    // Reads sample the array before this edge's write lands; only one
    // request is accepted per edge, so every earlier write is visible.
    always_comb begin
        push_rsp = '0;
        if (!in_range) begin
            push_rsp.err = 1'b1;
        end else if (!we_i) begin
            push_rsp.rdata = mem[mem_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            mem[mem_idx] <= be_merge(mem[mem_idx], wdata_i, be_i);
        end
    end

    obi_rsp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (RVALID_LATENCY)
    ) u_rsp_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (accept),
        .push_data_i  (push_rsp),
        .pop_i        (head_ready),
        .head_ready_o (head_ready),
        .head_data_o  (head_rsp),
        .full_o       (full),
        .count_o      (outstanding_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= head_ready;
            rdata_o  <= head_ready ? head_rsp.rdata : '0;
            err_o    <= head_ready & head_rsp.err;
        end
    end

endmodule
